// File: rtl/scale_selector.sv
// rtl/scale_selector.sv - debounced up/down pushbuttons driving a held scale number
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   btn_up_n      raw asynchronous key, low = pressed, steps scale up
//   btn_down_n    raw asynchronous key, low = pressed, steps scale down
//   scale         current scale, 1..NUM_SCALES, held between presses
//   scale_changed one-cycle strobe in the first cycle scale shows a new value
//
// Pipeline per button: 2-flop synchroniser -> debouncer -> rising-edge press
// pulse -> shared step logic. Pin edge to scale update is 2 + DEBOUNCE_CYCLES + 2.

module scale_selector #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_SCALES      = 5,
    parameter bit WRAP            = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up_n,
    input  logic       btn_down_n,
    output logic [7:0] scale,
    output logic       scale_changed
);

    localparam int               CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       SCALE_MAX = 8'(NUM_SCALES);
    localparam logic [7:0]       SCALE_MIN = 8'd1;

    // Bit 0 is the up button, bit 1 the down button throughout.
    logic [1:0] raw_n;
    logic [1:0] press;
    logic [7:0] next_scale;

    assign raw_n = {btn_down_n, btn_up_n};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic             sync1_n;
        logic             sync2_n;
        logic             p_sync;
        logic             deb;
        logic             deb_q;
        logic             press_r;
        logic [CNT_W-1:0] cnt;

        assign p_sync   = ~sync2_n;
        assign press[b] = press_r;

        // Synchronisers reset to the released (high) level so a held key
        // only reaches the debouncer two cycles after reset is released.
        always_ff @(posedge clk) begin
            if (reset) begin
                sync1_n <= 1'b1;
                sync2_n <= 1'b1;
            end else begin
                sync1_n <= raw_n[b];
                sync2_n <= sync1_n;
            end
        end

        // deb follows p_sync only after DEBOUNCE_CYCLES consecutive samples
        // that disagree with it; any agreeing sample restarts the count.
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt <= '0;
                deb <= 1'b0;
            end else if (p_sync == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= p_sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        // Press pulse on the debounced 0->1 edge only; release is ignored,
        // which is what prevents auto-repeat while a key is held.
        always_ff @(posedge clk) begin
            if (reset) begin
                deb_q   <= 1'b0;
                press_r <= 1'b0;
            end else begin
                deb_q   <= deb;
                press_r <= deb & ~deb_q;
            end
        end
    end

    // Simultaneous up and down presses cancel each other.
    always_comb begin
        next_scale = scale;
        if (press[0] && !press[1]) begin
            if (scale < SCALE_MAX) begin
                next_scale = scale + 8'd1;
            end else if (WRAP) begin
                next_scale = SCALE_MIN;
            end
        end else if (press[1] && !press[0]) begin
            if (scale > SCALE_MIN) begin
                next_scale = scale - 8'd1;
            end else if (WRAP) begin
                next_scale = SCALE_MAX;
            end
        end
    end

    // The strobe is registered alongside scale so both appear in the same
    // cycle; a saturated press leaves next_scale == scale and no strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            scale         <= SCALE_MIN;
            scale_changed <= 1'b0;
        end else begin
            scale         <= next_scale;
            scale_changed <= (next_scale != scale);
        end
    end

endmodule

// File: tb/tb_scale_selector.sv
// tb/tb_scale_selector.sv - randomized and directed bench for scale_selector

module tb_scale_selector;

    localparam int D    = 4;
    localparam int N    = 5;
    localparam int MAXC = 8192;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_up_n = 1'b1;
    logic       btn_down_n = 1'b1;
    logic [7:0] scale;
    logic       scale_changed;
    logic [7:0] scale_w;
    logic       scale_changed_w;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    scale_selector #(.DEBOUNCE_CYCLES(D), .NUM_SCALES(N), .WRAP(1'b0)) dut (
        .clk(clk), .reset(reset), .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
        .scale(scale), .scale_changed(scale_changed)
    );

    scale_selector #(.DEBOUNCE_CYCLES(D), .NUM_SCALES(N), .WRAP(1'b1)) dut_w (
        .clk(clk), .reset(reset), .btn_up_n(btn_up_n), .btn_down_n(btn_down_n),
        .scale(scale_w), .scale_changed(scale_changed_w)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: per-edge history of pins and reset. A debounced level
    // flips when the last D samples seen by the debouncer (pins delayed two
    // edges, forced released just after reset) all disagree with it and no
    // reset falls inside that window. A rising flip steps the scale two edges later.
    bit pin_u [MAXC];
    bit pin_d [MAXC];
    bit rst_h [MAXC];
    bit prs_u [MAXC];
    bit prs_d [MAXC];
    bit rise_u[MAXC];
    bit rise_d[MAXC];
    bit m_deb_u, m_deb_d;
    int m_scale = 1, m_scale_w = 1;
    bit m_chg, m_chg_w;
    bit model_live = 1'b0;
    int cyc = 0;

    function automatic bit seen(input int x, input bit up);
        if (x < 2) return 1'b0;
        if (rst_h[x-1] || rst_h[x-2]) return 1'b0;
        return up ? !pin_u[x-2] : !pin_d[x-2];
    endfunction

    function automatic bit flips(input int t, input bit up, input bit d);
        int x;
        for (int j = 0; j < D; j++) begin
            x = t - j;
            if (x < 0) return 1'b0;
            if (rst_h[x]) return 1'b0;
            if ((up ? prs_u[x] : prs_d[x]) == d) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int step(input int s, input bit up, input bit dn, input bit wrap);
        if (up && !dn) return (s < N) ? s + 1 : (wrap ? 1 : s);
        if (dn && !up) return (s > 1) ? s - 1 : (wrap ? N : s);
        return s;
    endfunction

    always @(posedge clk) begin
        int  ns, nsw;
        bit  up_ev, dn_ev;
        if (cyc < MAXC) begin
            rst_h[cyc]  = reset;
            pin_u[cyc]  = btn_up_n;
            pin_d[cyc]  = btn_down_n;
            prs_u[cyc]  = seen(cyc, 1'b1);
            prs_d[cyc]  = seen(cyc, 1'b0);
            rise_u[cyc] = 1'b0;
            rise_d[cyc] = 1'b0;
            if (reset) begin
                m_deb_u = 1'b0; m_deb_d = 1'b0;
                m_scale = 1; m_scale_w = 1;
                m_chg = 1'b0; m_chg_w = 1'b0;
                model_live = 1'b1;
            end else begin
                up_ev = (cyc >= 2) && rise_u[cyc-2] && !rst_h[cyc-1];
                dn_ev = (cyc >= 2) && rise_d[cyc-2] && !rst_h[cyc-1];
                if (flips(cyc, 1'b1, m_deb_u)) begin
                    m_deb_u = !m_deb_u;
                    rise_u[cyc] = m_deb_u;
                end
                if (flips(cyc, 1'b0, m_deb_d)) begin
                    m_deb_d = !m_deb_d;
                    rise_d[cyc] = m_deb_d;
                end
                ns  = step(m_scale,   up_ev, dn_ev, 1'b0);
                nsw = step(m_scale_w, up_ev, dn_ev, 1'b1);
                m_chg   = (ns != m_scale);
                m_chg_w = (nsw != m_scale_w);
                m_scale   = ns;
                m_scale_w = nsw;
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("scale", scale, m_scale);
            check("strobe", scale_changed, m_chg);
            check("scale_wrap", scale_w, m_scale_w);
            check("strobe_wrap", scale_changed_w, m_chg_w);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_up(input int low, input int high);
        btn_up_n = 1'b0; cycles(low); btn_up_n = 1'b1; cycles(high);
    endtask

    task automatic press_down(input int low, input int high);
        btn_down_n = 1'b0; cycles(low); btn_down_n = 1'b1; cycles(high);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; cycles(n); reset = 1'b0;
    endtask

    initial begin
        cycles(3);
        check("reset_scale", scale, 1);
        check("reset_strobe", scale_changed, 0);
        reset = 1'b0;
        cycles(50);
        check("idle_scale", scale, 1);

        // Clean press with exact latency.
        btn_up_n = 1'b0;
        cycles(7);
        check("lat_before", scale, 1);
        cycles(1);
        check("lat_scale", scale, 2);
        check("lat_strobe", scale_changed, 1);
        cycles(1);
        check("strobe_one_cycle", scale_changed, 0);
        cycles(11);
        btn_up_n = 1'b1;
        cycles(20);
        check("release_no_step", scale, 2);
        repeat (5) press_up(10, 20);
        check("saturate_top", scale, N);

        // Bounce rejection, then a stable low.
        repeat (10) begin
            btn_down_n = 1'b0; cycles(3);
            btn_down_n = 1'b1; cycles(1);
        end
        check("bounce_hold", scale, N);
        btn_down_n = 1'b0;
        cycles(7);
        check("bounce_before", scale, N);
        cycles(1);
        check("bounce_step", scale, N - 1);
        check("bounce_strobe", scale_changed, 1);
        cycles(12);
        btn_down_n = 1'b1;
        cycles(20);

        // Saturate at the bottom.
        repeat (3) press_down(10, 20);
        btn_down_n = 1'b0;
        cycles(8);
        check("saturate_bottom", scale, 1);
        check("saturate_no_strobe", scale_changed, 0);
        cycles(12);
        btn_down_n = 1'b1;
        cycles(20);

        // Wrap instance against saturating instance from a common reset.
        do_reset(3);
        cycles(5);
        btn_down_n = 1'b0;
        cycles(8);
        check("wrap_down", scale_w, N);
        check("wrap_down_strobe", scale_changed_w, 1);
        check("sat_down", scale, 1);
        cycles(12);
        btn_down_n = 1'b1;
        cycles(20);
        btn_up_n = 1'b0;
        cycles(8);
        check("wrap_up", scale_w, 1);
        check("wrap_up_strobe", scale_changed_w, 1);
        check("plain_up", scale, 2);
        cycles(12);
        btn_up_n = 1'b1;
        cycles(20);

        // Simultaneous and staggered presses.
        press_up(10, 20);
        btn_up_n = 1'b0; btn_down_n = 1'b0;
        cycles(20);
        btn_up_n = 1'b1; btn_down_n = 1'b1;
        cycles(20);
        check("simultaneous", scale, 3);
        btn_up_n = 1'b0;
        cycles(10);
        btn_down_n = 1'b0;
        cycles(20);
        btn_up_n = 1'b1; btn_down_n = 1'b1;
        cycles(20);
        check("staggered", scale, 3);

        // Reset while the up key is held with its count at 2.
        btn_up_n = 1'b0;
        cycles(4);
        do_reset(2);
        check("midhold_reset", scale, 1);
        cycles(7);
        check("midhold_before", scale, 1);
        cycles(1);
        check("midhold_step", scale, 2);
        check("midhold_strobe", scale_changed, 1);
        cycles(10);
        btn_up_n = 1'b1;
        cycles(20);

        // Random pin activity with occasional resets.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) btn_up_n = ~btn_up_n;
            if ($urandom_range(0, 5) == 0) btn_down_n = ~btn_down_n;
            reset = ($urandom_range(0, 199) == 0);
            cycles(1);
        end
        reset = 1'b0;
        btn_up_n = 1'b1;
        btn_down_n = 1'b1;
        cycles(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
